// File: rtl/rvv_backend_dispatch_uop_sequencer.sv
// Expands one decoded vector instruction into uop_num_m1+1 uops for the dispatch byte-type generator.
// Single-entry holding register with zero-bubble back-to-back handoff and synchronous trap flush.
module rvv_backend_dispatch_uop_sequencer #(
  parameter int VLEN            = 128,
  parameter int UOP_INDEX_WIDTH = 3,
  parameter int VL_WIDTH        = 8,
  parameter int VSTART_WIDTH    = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  input  logic [UOP_INDEX_WIDTH-1:0] inst_uop_num_m1,
  input  logic [VL_WIDTH-1:0]        inst_vl,
  input  logic [VSTART_WIDTH-1:0]    inst_vstart,
  input  logic [1:0]                 inst_vs1_eew,
  input  logic [1:0]                 inst_vs2_eew,
  input  logic [1:0]                 inst_vd_eew,
  input  logic                       inst_vm,
  input  logic                       inst_ignore_vma,
  input  logic                       inst_ignore_vta,
  input  logic [VLEN-1:0]            inst_v0,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [UOP_INDEX_WIDTH-1:0] uop_index,
  output logic                       uop_last,
  output logic [1:0]                 uop_eew_max,
  output logic [VL_WIDTH-1:0]        uop_vl,
  output logic [VSTART_WIDTH-1:0]    uop_vstart,
  output logic [1:0]                 uop_vs1_eew,
  output logic [1:0]                 uop_vs2_eew,
  output logic [1:0]                 uop_vd_eew,
  output logic                       uop_vm,
  output logic                       uop_ignore_vma,
  output logic                       uop_ignore_vta,
  output logic [VLEN-1:0]            uop_v0,
  output logic                       inst_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  // Illegal: reserved EEW encoding, or a 1:4 narrowing of an EEW32 source into an EEW8 destination.
  function automatic logic eew_legal(input logic [1:0] vs1, input logic [1:0] vs2, input logic [1:0] vd);
    logic legal;
    if (vs1 == 2'd3 || vs2 == 2'd3 || vd == 2'd3) begin
      legal = 1'b0;
    end else if (vd == 2'd0 && (vs1 == 2'd2 || vs2 == 2'd2)) begin
      legal = 1'b0;
    end else begin
      legal = 1'b1;
    end
    return legal;
  endfunction

  function automatic logic [1:0] eew_widest(input logic [1:0] vs1, input logic [1:0] vs2, input logic [1:0] vd);
    logic [1:0] widest;
    if (vs1 == 2'd2 || vs2 == 2'd2 || vd == 2'd2) begin
      widest = 2'd2;
    end else if (vs1 == 2'd1 || vs2 == 2'd1 || vd == 2'd1) begin
      widest = 2'd1;
    end else begin
      widest = 2'd0;
    end
    return widest;
  endfunction

  state_e                     state_r;
  state_e                     state_s;
  logic [UOP_INDEX_WIDTH-1:0] num_m1_r;
  logic [UOP_INDEX_WIDTH-1:0] index_s;
  logic [UOP_INDEX_WIDTH-1:0] idx_inc_s;
  logic                       valid_s;
  logic                       last_s;
  logic                       err_s;
  logic                       load_s;
  logic                       accept_s;
  logic                       consume_s;
  logic                       legal_s;

  assign consume_s  = uop_valid && uop_ready;
  assign inst_ready = !flush && (state_r == IDLE || (consume_s && uop_last));
  assign accept_s   = inst_valid && inst_ready;
  assign legal_s    = eew_legal(inst_vs1_eew, inst_vs2_eew, inst_vd_eew);
  assign idx_inc_s  = uop_index + {{(UOP_INDEX_WIDTH-1){1'b0}}, 1'b1};

  // Next-state and next-output selection; flush outranks accept, which outranks uop advance.
  always_comb begin
    state_s = state_r;
    valid_s = uop_valid;
    index_s = uop_index;
    last_s  = uop_last;
    err_s   = 1'b0;
    load_s  = 1'b0;
    if (flush) begin
      state_s = IDLE;
      valid_s = 1'b0;
      last_s  = 1'b0;
    end else if (accept_s) begin
      if (legal_s) begin
        load_s  = 1'b1;
        state_s = ISSUE;
        valid_s = 1'b1;
        index_s = {UOP_INDEX_WIDTH{1'b0}};
        last_s  = (inst_uop_num_m1 == {UOP_INDEX_WIDTH{1'b0}});
      end else begin
        // Dropped instruction; if it arrived on the last uop the sequencer still drains to idle.
        err_s   = 1'b1;
        state_s = IDLE;
        valid_s = 1'b0;
      end
    end else if (consume_s) begin
      if (uop_last) begin
        state_s = IDLE;
        valid_s = 1'b0;
      end else begin
        index_s = idx_inc_s;
        last_s  = (idx_inc_s == num_m1_r);
      end
    end else begin
      state_s = state_r;
    end
  end

  // Control registers: state, handshake and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      uop_valid <= 1'b0;
      uop_index <= {UOP_INDEX_WIDTH{1'b0}};
      uop_last  <= 1'b0;
      inst_err  <= 1'b0;
    end else begin
      state_r   <= state_s;
      uop_valid <= valid_s;
      uop_index <= index_s;
      uop_last  <= last_s;
      inst_err  <= err_s;
    end
  end

  // Instruction field holding register, loaded only on a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_m1_r       <= {UOP_INDEX_WIDTH{1'b0}};
      uop_eew_max    <= 2'd0;
      uop_vl         <= {VL_WIDTH{1'b0}};
      uop_vstart     <= {VSTART_WIDTH{1'b0}};
      uop_vs1_eew    <= 2'd0;
      uop_vs2_eew    <= 2'd0;
      uop_vd_eew     <= 2'd0;
      uop_vm         <= 1'b0;
      uop_ignore_vma <= 1'b0;
      uop_ignore_vta <= 1'b0;
      uop_v0         <= {VLEN{1'b0}};
    end else if (load_s) begin
      num_m1_r       <= inst_uop_num_m1;
      uop_eew_max    <= eew_widest(inst_vs1_eew, inst_vs2_eew, inst_vd_eew);
      uop_vl         <= inst_vl;
      uop_vstart     <= inst_vstart;
      uop_vs1_eew    <= inst_vs1_eew;
      uop_vs2_eew    <= inst_vs2_eew;
      uop_vd_eew     <= inst_vd_eew;
      uop_vm         <= inst_vm;
      uop_ignore_vma <= inst_ignore_vma;
      uop_ignore_vta <= inst_ignore_vta;
      uop_v0         <= inst_v0;
    end
  end

endmodule

// File: tb/tb_rvv_backend_dispatch_uop_sequencer.sv
// Bench for the uop sequencer: table vectors, hand-written corner sequences and a
// randomized run checked against a transaction-level queue model of the expected uop stream.
module tb_rvv_backend_dispatch_uop_sequencer;

  logic         clk = 1'b0;
  logic         rst_n, flush, inst_valid, inst_ready;
  logic [2:0]   inst_uop_num_m1;
  logic [7:0]   inst_vl;
  logic [6:0]   inst_vstart;
  logic [1:0]   inst_vs1_eew, inst_vs2_eew, inst_vd_eew;
  logic         inst_vm, inst_ignore_vma, inst_ignore_vta;
  logic [127:0] inst_v0;
  logic         uop_valid, uop_ready, uop_last, uop_vm, uop_ignore_vma, uop_ignore_vta, inst_err;
  logic [2:0]   uop_index;
  logic [1:0]   uop_eew_max, uop_vs1_eew, uop_vs2_eew, uop_vd_eew;
  logic [7:0]   uop_vl;
  logic [6:0]   uop_vstart;
  logic [127:0] uop_v0;

  always #5 clk = ~clk;

  rvv_backend_dispatch_uop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_uop_num_m1(inst_uop_num_m1), .inst_vl(inst_vl), .inst_vstart(inst_vstart),
    .inst_vs1_eew(inst_vs1_eew), .inst_vs2_eew(inst_vs2_eew), .inst_vd_eew(inst_vd_eew),
    .inst_vm(inst_vm), .inst_ignore_vma(inst_ignore_vma), .inst_ignore_vta(inst_ignore_vta),
    .inst_v0(inst_v0), .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_index(uop_index),
    .uop_last(uop_last), .uop_eew_max(uop_eew_max), .uop_vl(uop_vl), .uop_vstart(uop_vstart),
    .uop_vs1_eew(uop_vs1_eew), .uop_vs2_eew(uop_vs2_eew), .uop_vd_eew(uop_vd_eew), .uop_vm(uop_vm),
    .uop_ignore_vma(uop_ignore_vma), .uop_ignore_vta(uop_ignore_vta), .uop_v0(uop_v0),
    .inst_err(inst_err)
  );

  typedef struct {
    logic [2:0]   num_m1;
    logic [7:0]   vl;
    logic [6:0]   vstart;
    logic [1:0]   vs1, vs2, vd;
    logic         vm, vma, vta;
    logic [127:0] v0;
  } inst_t;

  typedef struct {
    inst_t      in;
    logic       exp_err;
    logic [1:0] exp_max;
  } tv_t;

  typedef struct {
    logic [29:0]  f;
    logic [127:0] v0;
  } exp_t;

  int    total = 0;
  int    bad = 0;
  exp_t  q[$];
  inst_t cur;
  bit    taken = 1'b0;
  bit    err_pend = 1'b0;
  tv_t   tv[9];

  logic [29:0] act_f;
  assign act_f = {uop_index, uop_last, uop_eew_max, uop_vl, uop_vstart, uop_vs1_eew,
                  uop_vs2_eew, uop_vd_eew, uop_vm, uop_ignore_vma, uop_ignore_vta};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic inst_t mk(input logic [2:0] n, input logic [7:0] vl,
                               input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d);
    inst_t i;
    i.num_m1 = n; i.vl = vl; i.vstart = 7'd3;
    i.vs1 = s1; i.vs2 = s2; i.vd = d;
    i.vm = 1'b0; i.vma = 1'b1; i.vta = 1'b0;
    i.v0 = {4{32'hA5C3_0F96}} ^ {120'd0, vl};
    return i;
  endfunction

  function automatic logic [1:0] rnd_eew();
    logic [1:0] e;
    if ($urandom_range(0, 11) == 0) e = 2'd3;
    else e = 2'($urandom_range(0, 2));
    return e;
  endfunction

  function automatic inst_t rand_inst();
    inst_t i;
    i.num_m1 = 3'($urandom_range(0, 7));
    i.vl     = 8'($urandom_range(0, 128));
    i.vstart = 7'($urandom_range(0, 127));
    i.vs1 = rnd_eew(); i.vs2 = rnd_eew(); i.vd = rnd_eew();
    i.vm  = 1'($urandom_range(0, 1));
    i.vma = 1'($urandom_range(0, 1));
    i.vta = 1'($urandom_range(0, 1));
    i.v0  = {$urandom(), $urandom(), $urandom(), $urandom()};
    return i;
  endfunction

  function automatic bit model_legal(input inst_t i);
    bit reserved, narrow4;
    reserved = (i.vs1 == 2'd3) || (i.vs2 == 2'd3) || (i.vd == 2'd3);
    narrow4  = (i.vd == 2'd0) && ((i.vs1 == 2'd2) || (i.vs2 == 2'd2));
    return !reserved && !narrow4;
  endfunction

  // Expected visible fields of uop k of instruction i.
  function automatic logic [29:0] pack_exp(input inst_t i, input int k);
    int mx;
    logic [2:0] kk;
    logic lst;
    mx = int'(i.vs1);
    if (int'(i.vs2) > mx) mx = int'(i.vs2);
    if (int'(i.vd) > mx) mx = int'(i.vd);
    kk  = k[2:0];
    lst = (k == int'(i.num_m1));
    return {kk, lst, mx[1:0], i.vl, i.vstart, i.vs1, i.vs2, i.vd, i.vm, i.vma, i.vta};
  endfunction

  task automatic drive_inst(input inst_t i);
    inst_uop_num_m1 = i.num_m1; inst_vl = i.vl; inst_vstart = i.vstart;
    inst_vs1_eew = i.vs1; inst_vs2_eew = i.vs2; inst_vd_eew = i.vd;
    inst_vm = i.vm; inst_ignore_vma = i.vma; inst_ignore_vta = i.vta; inst_v0 = i.v0;
  endtask

  task automatic apply_tv(input tv_t t);
    @(negedge clk);
    drive_inst(t.in); inst_valid = 1'b1; uop_ready = 1'b1;
    #1 chk("tv_ready", 128'(inst_ready), 128'(1'b1));
    @(negedge clk);
    inst_valid = 1'b0;
    chk("tv_err", 128'(inst_err), 128'(t.exp_err));
    if (t.exp_err) begin
      chk("tv_noval", 128'(uop_valid), 128'(1'b0));
      @(negedge clk);
      chk("tv_errpulse", 128'(inst_err), 128'(1'b0));
      chk("tv_noval2", 128'(uop_valid), 128'(1'b0));
    end else begin
      for (int k = 0; k <= int'(t.in.num_m1); k++) begin
        if (k > 0) @(negedge clk);
        chk("tv_valid", 128'(uop_valid), 128'(1'b1));
        chk("tv_idx", 128'(uop_index), 128'(k));
        chk("tv_last", 128'(uop_last), 128'(k == int'(t.in.num_m1)));
        chk("tv_max", 128'(uop_eew_max), 128'(t.exp_max));
        chk("tv_vl", 128'(uop_vl), 128'(t.in.vl));
        chk("tv_v0", uop_v0, t.in.v0);
      end
      @(negedge clk);
      chk("tv_idle", 128'(uop_valid), 128'(1'b0));
    end
  endtask

  // One randomized cycle; the queue holds the remaining uops of the instruction in flight.
  task automatic rnd_cycle(input bit offer);
    bit er;
    @(negedge clk);
    if (taken) begin
      inst_valid = 1'b0;
      taken = 1'b0;
    end
    chk("rnd_err", 128'(inst_err), 128'(err_pend));
    err_pend = 1'b0;
    chk("rnd_valid", 128'(uop_valid), 128'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rnd_fields", 128'(act_f), 128'(q[0].f));
      chk("rnd_v0", uop_v0, q[0].v0);
    end
    uop_ready = offer ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (offer && !inst_valid && $urandom_range(0, 1) == 0) begin
      cur = rand_inst();
      drive_inst(cur);
      inst_valid = 1'b1;
    end
    #1;
    er = (q.size() == 0) || (uop_ready && q.size() == 1);
    chk("rnd_ready", 128'(inst_ready), 128'(er));
    if (q.size() != 0 && uop_ready) q.delete(0);
    if (inst_valid && er) begin
      taken = 1'b1;
      if (model_legal(cur)) begin
        for (int k = 0; k <= int'(cur.num_m1); k++) q.push_back('{pack_exp(cur, k), cur.v0});
      end else begin
        err_pend = 1'b1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_t a, b;
    logic [29:0] snap;
    rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; uop_ready = 1'b0;
    drive_inst(mk(3'd0, 8'd0, 2'd0, 2'd0, 2'd0));

    tv[0] = '{mk(3'd3, 8'd40,  2'd0, 2'd0, 2'd0), 1'b0, 2'd0};
    tv[1] = '{mk(3'd1, 8'd16,  2'd0, 2'd0, 2'd1), 1'b0, 2'd1};
    tv[2] = '{mk(3'd0, 8'd8,   2'd0, 2'd2, 2'd0), 1'b1, 2'd0};
    tv[3] = '{mk(3'd2, 8'd9,   2'd3, 2'd0, 2'd0), 1'b1, 2'd0};
    tv[4] = '{mk(3'd1, 8'd50,  2'd2, 2'd2, 2'd1), 1'b0, 2'd2};
    tv[5] = '{mk(3'd7, 8'd0,   2'd0, 2'd0, 2'd2), 1'b0, 2'd2};
    tv[6] = '{mk(3'd0, 8'd128, 2'd1, 2'd1, 2'd1), 1'b0, 2'd1};
    tv[7] = '{mk(3'd3, 8'd12,  2'd0, 2'd0, 2'd3), 1'b1, 2'd0};
    tv[8] = '{mk(3'd2, 8'd20,  2'd2, 2'd0, 2'd0), 1'b1, 2'd0};

    #2;
    chk("rst_valid", 128'(uop_valid), 128'(1'b0));
    chk("rst_index", 128'(uop_index), 128'(3'd0));
    chk("rst_last", 128'(uop_last), 128'(1'b0));
    chk("rst_err", 128'(inst_err), 128'(1'b0));
    chk("rst_fields", 128'(act_f), 128'(30'd0));
    chk("rst_v0", uop_v0, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", 128'(inst_ready), 128'(1'b1));

    for (int t = 0; t < 9; t++) apply_tv(tv[t]);

    // Back-to-back: B waits through A and starts with no idle gap.
    a = mk(3'd2, 8'd20, 2'd0, 2'd0, 2'd0);
    b = mk(3'd1, 8'd77, 2'd0, 2'd1, 2'd1);
    @(negedge clk); drive_inst(a); inst_valid = 1'b1; uop_ready = 1'b1;
    @(negedge clk); drive_inst(b);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("b2b_idx", 128'(uop_index), 128'(k));
      chk("b2b_ready", 128'(inst_ready), 128'(k == 2));
    end
    @(negedge clk); inst_valid = 1'b0;
    chk("b2b_valid", 128'(uop_valid), 128'(1'b1));
    chk("b2b_fields0", 128'(act_f), 128'(pack_exp(b, 0)));
    @(negedge clk);
    chk("b2b_fields1", 128'(act_f), 128'(pack_exp(b, 1)));
    @(negedge clk);
    chk("b2b_idle", 128'(uop_valid), 128'(1'b0));

    // Backpressure: hold at index 1 for five cycles.
    a = mk(3'd3, 8'd64, 2'd1, 2'd1, 2'd0);
    @(negedge clk); drive_inst(a); inst_valid = 1'b1; uop_ready = 1'b1;
    @(negedge clk); inst_valid = 1'b0;
    @(negedge clk); uop_ready = 1'b0;
    snap = act_f;
    chk("bp_idx1", 128'(act_f), 128'(pack_exp(a, 1)));
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_valid", 128'(uop_valid), 128'(1'b1));
      chk("bp_stable", 128'(act_f), 128'(snap));
      chk("bp_v0", uop_v0, a.v0);
    end
    uop_ready = 1'b1;
    @(negedge clk); chk("bp_resume", 128'(act_f), 128'(pack_exp(a, 2)));
    @(negedge clk); chk("bp_last", 128'(act_f), 128'(pack_exp(a, 3)));
    @(negedge clk); chk("bp_idle", 128'(uop_valid), 128'(1'b0));

    // Flush at index 2 of 8 with uop_ready and a pending instruction.
    a = mk(3'd7, 8'd100, 2'd0, 2'd0, 2'd0);
    b = mk(3'd0, 8'd5, 2'd1, 2'd0, 2'd1);
    @(negedge clk); drive_inst(a); inst_valid = 1'b1; uop_ready = 1'b1;
    @(negedge clk); inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_idx2", 128'(uop_index), 128'(3'd2));
    flush = 1'b1; drive_inst(b); inst_valid = 1'b1;
    #1 chk("fl_ready", 128'(inst_ready), 128'(1'b0));
    @(negedge clk); flush = 1'b0;
    chk("fl_valid", 128'(uop_valid), 128'(1'b0));
    chk("fl_last", 128'(uop_last), 128'(1'b0));
    chk("fl_err", 128'(inst_err), 128'(1'b0));
    #1 chk("fl_ready_idle", 128'(inst_ready), 128'(1'b1));
    @(negedge clk); inst_valid = 1'b0;
    chk("fl_accept", 128'(uop_valid), 128'(1'b1));
    chk("fl_fields", 128'(act_f), 128'(pack_exp(b, 0)));
    @(negedge clk);
    chk("fl_idle", 128'(uop_valid), 128'(1'b0));

    // Asynchronous reset while index 5 is presented.
    a = mk(3'd7, 8'd33, 2'd0, 2'd1, 2'd1);
    @(negedge clk); drive_inst(a); inst_valid = 1'b1; uop_ready = 1'b1;
    @(negedge clk); inst_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("ar_idx5", 128'(act_f), 128'(pack_exp(a, 5)));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(uop_valid), 128'(1'b0));
    chk("ar_index", 128'(uop_index), 128'(3'd0));
    chk("ar_fields", 128'(act_f), 128'(30'd0));
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ar_ready", 128'(inst_ready), 128'(1'b1));
    chk("ar_valid2", 128'(uop_valid), 128'(1'b0));

    // Randomized traffic against the queue model, then a bounded drain.
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 200 && (q.size() != 0 || inst_valid || err_pend); c++) rnd_cycle(1'b0);
    chk("drain_empty", 128'(q.size()), 128'(0));
    chk("drain_err", 128'(err_pend), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
